// File: rtl/debug_step_controller_if.sv
// Control/status bundle between the board UI, the step controller and the CPU core.
// step_count exists only when DEBUG_STEP_COUNT_EN is defined.
interface debug_step_controller_if;
    logic [9:0]  debug_switch;
    logic [2:0]  debug_button;
    logic        instr_done;
    logic        cpu_en;
    logic        step_busy;
    logic [1:0]  mode;
    logic        step_timeout;
`ifdef DEBUG_STEP_COUNT_EN
    logic [15:0] step_count;

    modport master (output debug_switch, debug_button, instr_done,
                    input  cpu_en, step_busy, mode, step_timeout, step_count);
    modport slave  (input  debug_switch, debug_button, instr_done,
                    output cpu_en, step_busy, mode, step_timeout, step_count);
`else
    modport master (output debug_switch, debug_button, instr_done,
                    input  cpu_en, step_busy, mode, step_timeout);
    modport slave  (input  debug_switch, debug_button, instr_done,
                    output cpu_en, step_busy, mode, step_timeout);
`endif
endinterface

// File: rtl/debug_step_controller.sv
// CPU clock-enable sequencer: free run, single-cycle step or single-instruction step.
// Optional completed-step counter enabled by DEBUG_STEP_COUNT_EN.
module debug_step_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned INSTR_TIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    debug_step_controller_if.slave bus
);
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned IC_W = $clog2(INSTR_TIMEOUT + 1);

    typedef enum logic [1:0] {
        MODE_FREE  = 2'b00,
        MODE_CYCLE = 2'b01,
        MODE_INSTR = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        S_RUN,
        S_HALT,
        S_CYCLE,
        S_INSTR
    } state_e;

    // Index 0 = single-step button (bit 2), index 1 = instruction-step button (bit 1)
    logic [1:0]      btn_raw;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      deb_q, deb_d;
    logic [1:0]      press_q, press_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    mode_e           mode_d, mode_q;
    state_e          state_q;
    logic            cpu_en_q;
    logic            busy_q;
    logic            timeout_q;
    logic [IC_W-1:0] icnt_q, icnt_d;
    logic            unused_inputs;
`ifdef DEBUG_STEP_COUNT_EN
    logic [15:0]     step_count_q;
`endif

    assign btn_raw       = {bus.debug_button[1], bus.debug_button[2]};
    assign unused_inputs = ^{bus.debug_switch[8:1], bus.debug_button[0]};

    // A new level is accepted after DEBOUNCE_CYCLES consecutive samples that differ from it
    always_comb begin
        deb_d = deb_q;
        for (int unsigned i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        press_d = deb_q & ~deb_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            deb_q   <= '1;
            press_q <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            press_q <= press_d;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    always_comb begin
        if (bus.debug_switch[9]) begin
            mode_d = MODE_INSTR;
        end else if (bus.debug_switch[0]) begin
            mode_d = MODE_CYCLE;
        end else begin
            mode_d = MODE_FREE;
        end
        icnt_d = (icnt_q == IC_W'(INSTR_TIMEOUT)) ? icnt_q : icnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_HALT;
            mode_q       <= MODE_FREE;
            cpu_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            icnt_q       <= '0;
`ifdef DEBUG_STEP_COUNT_EN
            step_count_q <= '0;
`endif
        end else begin
            mode_q <= mode_d;
            // Free-run selection overrides every state, aborting steps without a timeout
            if (mode_d == MODE_FREE) begin
                state_q      <= S_RUN;
                cpu_en_q     <= 1'b1;
                busy_q       <= 1'b0;
`ifdef DEBUG_STEP_COUNT_EN
                step_count_q <= '0;
`endif
            end else begin
                case (state_q)
                    S_RUN: begin
                        state_q  <= S_HALT;
                        cpu_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                    S_HALT: begin
                        if (mode_d == MODE_CYCLE && press_q[0]) begin
                            state_q  <= S_CYCLE;
                            cpu_en_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end else if (mode_d == MODE_INSTR && press_q[1]) begin
                            state_q   <= S_INSTR;
                            cpu_en_q  <= 1'b1;
                            busy_q    <= 1'b1;
                            timeout_q <= 1'b0;
                            icnt_q    <= '0;
                        end
                    end
                    S_CYCLE: begin
                        state_q      <= S_HALT;
                        cpu_en_q     <= 1'b0;
                        busy_q       <= 1'b0;
`ifdef DEBUG_STEP_COUNT_EN
                        step_count_q <= step_count_q + 16'd1;
`endif
                    end
                    S_INSTR: begin
                        icnt_q <= icnt_d;
                        if (bus.instr_done) begin
                            state_q      <= S_HALT;
                            cpu_en_q     <= 1'b0;
                            busy_q       <= 1'b0;
`ifdef DEBUG_STEP_COUNT_EN
                            step_count_q <= step_count_q + 16'd1;
`endif
                        end else if (icnt_d == IC_W'(INSTR_TIMEOUT)) begin
                            state_q   <= S_HALT;
                            cpu_en_q  <= 1'b0;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= S_HALT;
                        cpu_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.cpu_en       = cpu_en_q;
    assign bus.step_busy    = busy_q;
    assign bus.mode         = mode_q;
    assign bus.step_timeout = timeout_q;
`ifdef DEBUG_STEP_COUNT_EN
    assign bus.step_count   = step_count_q;
`endif
endmodule

// File: tb/tb_debug_step_controller.sv
// Bench for debug_step_controller: randomized step sequences scored against arithmetic expectations.
module tb_debug_step_controller;
    localparam int unsigned DEB = 4;
    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned model_to = 0;
    int unsigned model_cnt = 0;
    int unsigned hi, bm, k, g, kind, found;

    debug_step_controller_if dif();

    debug_step_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .INSTR_TIMEOUT  (TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Don't-care switch bits are randomized; bit 9 and bit 0 come from the caller
    task automatic set_mode(input logic [9:0] sw);
        @(negedge clk);
        dif.debug_switch = sw | (10'($urandom) & 10'h1FE);
        repeat (2) @(negedge clk);
    endtask

    // Hold a button, optionally retire the instruction on the k-th enabled cycle,
    // optionally change the switches after chg_at enabled cycles.
    task automatic do_step(input int unsigned bidx, input int unsigned kk,
                           input int unsigned chg_at, input logic [9:0] chg_sw,
                           output int unsigned nhi, output int unsigned nbm);
        nhi = 0;
        nbm = 0;
        dif.debug_button[bidx] = 1'b0;
        for (int unsigned c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 10) dif.debug_button = 3'b111;
            if (dif.cpu_en === 1'b1) nhi++;
            if (dif.step_busy !== dif.cpu_en) nbm++;
            dif.instr_done = (dif.cpu_en === 1'b1) && (nhi == kk);
            if (chg_at != 0 && nhi == chg_at && dif.cpu_en === 1'b1) dif.debug_switch = chg_sw;
        end
        dif.instr_done = 1'b0;
    endtask

    task automatic glitch(input int unsigned bidx, input int unsigned len, output int unsigned nhi);
        nhi = 0;
        dif.debug_button[bidx] = 1'b0;
        for (int unsigned c = 0; c < len + 14; c++) begin
            @(negedge clk);
            if (c == len - 1) dif.debug_button = 3'b111;
            if (dif.cpu_en === 1'b1) nhi++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.debug_switch = 10'h000;
        dif.debug_button = 3'b111;
        dif.instr_done   = 1'b0;
        #12;
        check("rst_cpu_en", dif.cpu_en, 0);
        check("rst_busy", dif.step_busy, 0);
        check("rst_mode", dif.mode, 0);
        check("rst_timeout", dif.step_timeout, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("run_cpu_en", dif.cpu_en, 1);
        check("run_busy", dif.step_busy, 0);
        check("run_mode", dif.mode, 0);
`ifdef DEBUG_STEP_COUNT_EN
        check("run_count", dif.step_count, 0);
`endif

        @(negedge clk);
        dif.debug_switch = 10'h001;
        @(negedge clk);
        check("halt_cpu_en", dif.cpu_en, 0);
        check("halt_mode", dif.mode, 1);

        do_step(2, 0, 0, 10'h0, hi, bm);
        check("cycle_pulses", hi, 1);
        check("cycle_busy", bm, 0);
        model_cnt++;

        for (int unsigned it = 0; it < 10; it++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    set_mode(10'h001);
                    do_step(2, 0, 0, 10'h0, hi, bm);
                    check("rnd_cycle_pulses", hi, 1);
                    check("rnd_cycle_busy", bm, 0);
                    model_cnt++;
                end
                1: begin
                    k = $urandom_range(1, 20);
                    set_mode(10'h200 | 10'($urandom_range(0, 1)));
                    do_step(1, k, 0, 10'h0, hi, bm);
                    check("rnd_instr_len", hi, (k < TMO) ? k : TMO);
                    check("rnd_instr_busy", bm, 0);
                    model_to = (k > TMO) ? 1 : 0;
                    if (k <= TMO) model_cnt++;
                end
                2: begin
                    g = $urandom_range(1, DEB - 1);
                    if ($urandom_range(0, 1) == 1) begin
                        set_mode(10'h001);
                        glitch(2, g, hi);
                    end else begin
                        set_mode(10'h200);
                        glitch(1, g, hi);
                    end
                    check("rnd_glitch", hi, 0);
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) begin
                        set_mode(10'h001);
                        do_step(1, 0, 0, 10'h0, hi, bm);
                    end else begin
                        set_mode(10'h200);
                        do_step(2, 0, 0, 10'h0, hi, bm);
                    end
                    check("rnd_wrong_button", hi, 0);
                end
            endcase
            check("rnd_timeout", dif.step_timeout, model_to);
`ifdef DEBUG_STEP_COUNT_EN
            check("rnd_count", dif.step_count, model_cnt);
`endif
        end

        set_mode(10'h200);
        do_step(1, 5, 0, 10'h0, hi, bm);
        check("instr5_len", hi, 5);
        check("instr5_timeout", dif.step_timeout, 0);
        model_cnt++;

        set_mode(10'h200);
        do_step(1, 6, 2, 10'h001, hi, bm);
        check("instr_modechg_len", hi, 6);
        check("instr_modechg_mode", dif.mode, 1);
        model_cnt++;

        set_mode(10'h200);
        do_step(1, 0, 0, 10'h0, hi, bm);
        check("tmo_len", hi, TMO);
        check("tmo_flag", dif.step_timeout, 1);
        set_mode(10'h001);
        do_step(2, 0, 0, 10'h0, hi, bm);
        check("tmo_after_cycle", hi, 1);
        check("tmo_sticky_cycle", dif.step_timeout, 1);
        model_cnt++;
        set_mode(10'h200);
        do_step(2, 0, 0, 10'h0, hi, bm);
        check("tmo_wrong_button", hi, 0);
        check("tmo_sticky_wrong", dif.step_timeout, 1);
        do_step(1, 2, 0, 10'h0, hi, bm);
        check("tmo_clear_len", hi, 2);
        check("tmo_clear_flag", dif.step_timeout, 0);
        model_cnt++;
`ifdef DEBUG_STEP_COUNT_EN
        check("dir_count", dif.step_count, model_cnt);
`endif

        set_mode(10'h200);
        dif.debug_button[1] = 1'b0;
        hi = 0;
        for (int unsigned c = 0; c < 40 && hi < 4; c++) begin
            @(negedge clk);
            if (dif.cpu_en === 1'b1) hi++;
        end
        check("abort_reach", hi, 4);
        dif.debug_switch = 10'h000;
        model_cnt = 0;
        @(negedge clk);
        check("abort_cpu_en", dif.cpu_en, 1);
        check("abort_busy", dif.step_busy, 0);
        check("abort_mode", dif.mode, 0);
        check("abort_timeout", dif.step_timeout, 0);
        dif.debug_button = 3'b111;
        repeat (10) @(negedge clk);
        check("abort_still_run", dif.cpu_en, 1);
`ifdef DEBUG_STEP_COUNT_EN
        check("abort_count", dif.step_count, 0);
`endif

        set_mode(10'h001);
        dif.debug_button[2] = 1'b0;
        found = 0;
        for (int unsigned c = 0; c < 30 && found == 0; c++) begin
            @(negedge clk);
            if (dif.cpu_en === 1'b1) found = 1;
        end
        check("rstmid_reach", found, 1);
        rst = 1'b1;
        #1;
        check("rstmid_cpu_en", dif.cpu_en, 0);
        check("rstmid_busy", dif.step_busy, 0);
        dif.debug_button = 3'b111;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmid_halt", dif.cpu_en, 0);
        check("rstmid_mode", dif.mode, 1);
        model_to = 0;
        model_cnt = 0;

`ifdef DEBUG_STEP_COUNT_EN
        for (int unsigned i = 0; i < 3; i++) begin
            set_mode(10'h001);
            do_step(2, 0, 0, 10'h0, hi, bm);
            model_cnt++;
        end
        for (int unsigned i = 0; i < 2; i++) begin
            set_mode(10'h200);
            do_step(1, 3, 0, 10'h0, hi, bm);
            model_cnt++;
        end
        check("cnt_five", dif.step_count, model_cnt);
        set_mode(10'h000);
        model_cnt = 0;
        check("cnt_free_clear", dif.step_count, model_cnt);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
